// File: rtl/data_sync_handshake.sv
// Destination-domain bus synchronizer: synchronizes a level enable, captures the
// foreign bus on its rising edge and holds it in a valid/ready register with overrun.
module data_sync_handshake #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 BUS_ENABLE,
    input  logic                 DEST_READY,
    input  logic                 CLR_OVERRUN,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 ENABLE_PULSE,
    output logic                 SYNC_VALID,
    output logic                 OVERRUN
);

    logic [NUM_STAGES-1:0] chain;
    logic                  en_d;
    logic                  cap;

    // Metastability chain for the level enable plus one flop for edge detection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            chain <= '0;
            en_d  <= 1'b0;
        end else begin
            chain <= {chain[NUM_STAGES-2:0], BUS_ENABLE};
            en_d  <= chain[NUM_STAGES-1];
        end
    end

    assign cap = chain[NUM_STAGES-1] & ~en_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            SYNC_BUS     <= '0;
            ENABLE_PULSE <= 1'b0;
        end else begin
            ENABLE_PULSE <= cap;
            if (cap) begin
                SYNC_BUS <= UNSYNC_BUS;
            end
        end
    end

    // A capture always wins over consumption, so data landing on an accept stays valid.
    always_ff @(posedge CLK) begin
        if (RST) begin
            SYNC_VALID <= 1'b0;
        end else if (cap) begin
            SYNC_VALID <= 1'b1;
        end else if (SYNC_VALID && DEST_READY) begin
            SYNC_VALID <= 1'b0;
        end
    end

    // Setting the sticky flag takes priority over a clear on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OVERRUN <= 1'b0;
        end else if (cap && SYNC_VALID && !DEST_READY) begin
            OVERRUN <= 1'b1;
        end else if (CLR_OVERRUN) begin
            OVERRUN <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_sync_handshake.sv
// Directed bench for data_sync_handshake: a scoreboard queue holds expected captures
// and is drained whenever the two-stage instance emits ENABLE_PULSE.
module tb_data_sync_handshake;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       bus_en;
    logic       ready;
    logic       clr;

    logic [7:0] sync_bus2, sync_bus3;
    logic       pulse2, pulse3;
    logic       valid2, valid3;
    logic       ovr2, ovr3;

    int         total = 0;
    int         bad = 0;
    logic [7:0] sb_q[$];
    logic [7:0] exp_data;

    always #5 clk = ~clk;

    data_sync_handshake #(.NUM_STAGES(2), .BUS_WIDTH(8)) dut (
        .CLK(clk), .RST(rst), .UNSYNC_BUS(data), .BUS_ENABLE(bus_en),
        .DEST_READY(ready), .CLR_OVERRUN(clr),
        .SYNC_BUS(sync_bus2), .ENABLE_PULSE(pulse2), .SYNC_VALID(valid2), .OVERRUN(ovr2)
    );

    data_sync_handshake #(.NUM_STAGES(3), .BUS_WIDTH(8)) dut3 (
        .CLK(clk), .RST(rst), .UNSYNC_BUS(data), .BUS_ENABLE(bus_en),
        .DEST_READY(ready), .CLR_OVERRUN(clr),
        .SYNC_BUS(sync_bus3), .ENABLE_PULSE(pulse3), .SYNC_VALID(valid3), .OVERRUN(ovr3)
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One rising edge, then sample 1 time unit later and drain the scoreboard on a pulse.
    task automatic step();
        @(posedge clk);
        #1;
        if (pulse2) begin
            if (sb_q.size() == 0) begin
                check_output("unexpected_pulse", 32'(pulse2), 32'd0);
            end else begin
                exp_data = sb_q.pop_front();
                check_output("sb_data", 32'(sync_bus2), 32'(exp_data));
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic start_xfer(input logic [7:0] value);
        data   = value;
        bus_en = 1'b1;
        sb_q.push_back(value);
    endtask

    initial begin
        rst    = 1'b1;
        bus_en = 1'b1;
        data   = 8'hA5;
        ready  = 1'b0;
        clr    = 1'b0;

        // Reset holds every output low even with the enable asserted.
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("rst_outs2", {sync_bus2, pulse2, valid2, ovr2}, 32'd0);
            check_output("rst_outs3", {sync_bus3, pulse3, valid3, ovr3}, 32'd0);
        end
        rst    = 1'b0;
        bus_en = 1'b0;
        steps(4);
        check_output("idle_pulse", 32'(pulse2), 32'd0);

        // Basic transfer with three-edge latency.
        start_xfer(8'h3C);
        steps(2);
        check_output("basic_early_pulse", 32'(pulse2), 32'd0);
        check_output("basic_early_valid", 32'(valid2), 32'd0);
        step();
        check_output("basic_pulse", 32'(pulse2), 32'd1);
        check_output("basic_bus", 32'(sync_bus2), 32'h3C);
        check_output("basic_valid", 32'(valid2), 32'd1);
        step();
        check_output("basic_pulse_off", 32'(pulse2), 32'd0);
        steps(2);
        bus_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_output("fall_no_pulse", 32'(pulse2), 32'd0);
            check_output("hold_valid", 32'(valid2), 32'd1);
            check_output("hold_bus", 32'(sync_bus2), 32'h3C);
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
        check_output("accept_valid", 32'(valid2), 32'd0);
        check_output("accept_bus_kept", 32'(sync_bus2), 32'h3C);

        // Overrun: second capture while the first is unconsumed.
        start_xfer(8'h11);
        steps(3);
        check_output("ovr_first_bus", 32'(sync_bus2), 32'h11);
        check_output("ovr_first_flag", 32'(ovr2), 32'd0);
        steps(3);
        bus_en = 1'b0;
        steps(4);
        start_xfer(8'h22);
        steps(3);
        check_output("ovr_bus", 32'(sync_bus2), 32'h22);
        check_output("ovr_set", 32'(ovr2), 32'd1);
        steps(3);
        bus_en = 1'b0;
        clr    = 1'b1;
        step();
        clr = 1'b0;
        check_output("ovr_cleared", 32'(ovr2), 32'd0);
        steps(3);

        // Clear held on the overrun capture edge: set wins.
        start_xfer(8'h33);
        steps(2);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_output("set_wins_flag", 32'(ovr2), 32'd1);
        check_output("set_wins_bus", 32'(sync_bus2), 32'h33);
        steps(3);
        bus_en = 1'b0;
        steps(4);
        ready = 1'b1;
        clr   = 1'b1;
        step();
        ready = 1'b0;
        clr   = 1'b0;
        check_output("drain_valid", 32'(valid2), 32'd0);
        check_output("drain_ovr", 32'(ovr2), 32'd0);

        // Capture and acceptance on the same edge.
        start_xfer(8'h40);
        steps(3);
        check_output("sim_first_valid", 32'(valid2), 32'd1);
        steps(3);
        bus_en = 1'b0;
        steps(4);
        start_xfer(8'h41);
        steps(2);
        ready = 1'b1;
        step();
        ready = 1'b0;
        check_output("sim_bus", 32'(sync_bus2), 32'h41);
        check_output("sim_valid", 32'(valid2), 32'd1);
        check_output("sim_ovr", 32'(ovr2), 32'd0);
        steps(3);
        bus_en = 1'b0;
        steps(4);
        ready = 1'b1;
        step();
        ready = 1'b0;
        steps(3);

        // Reset one cycle after the enable rises; capture must follow the release.
        start_xfer(8'h5A);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_output("mid_rst_bus", 32'(sync_bus2), 32'd0);
        check_output("mid_rst_valid", 32'(valid2), 32'd0);
        check_output("mid_rst_pulse", 32'(pulse2), 32'd0);
        steps(2);
        check_output("rel2_pulse_early", 32'(pulse2), 32'd0);
        step();
        check_output("rel2_pulse", 32'(pulse2), 32'd1);
        check_output("rel2_bus", 32'(sync_bus2), 32'h5A);
        check_output("rel3_pulse_early", 32'(pulse3), 32'd0);
        step();
        check_output("rel2_pulse_off", 32'(pulse2), 32'd0);
        check_output("rel3_pulse", 32'(pulse3), 32'd1);
        check_output("rel3_bus", 32'(sync_bus3), 32'h5A);
        for (int i = 0; i < 4; i++) begin
            step();
            check_output("rel_single_pulse2", 32'(pulse2), 32'd0);
            check_output("rel_single_pulse3", 32'(pulse3), 32'd0);
        end
        bus_en = 1'b0;
        steps(4);

        check_output("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
